llc_input_arbiter: RTL and testbench

//  Parametrised successor to the LLC input decoder. Selects one of NUM_SRC incoming sources per cycle
//  (rst/rsp/req/dma-req/resume, index 0 = highest priority) under per-source block masks.

---
 rtl/llc_arb_pkg.sv | 36 +++
 rtl/llc_arb_fifo.sv | 66 ++++++
 rtl/llc_input_arbiter.sv | 173 +++++++++++++++++
 tb/tb_llc_input_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_arb_pkg.sv
// Shared types and helpers for the LLC input arbiter.
// Line address and set widths come from LINE_ADDR_BITS / LLC_SET_BITS when the
// build provides them; the fallbacks below keep a standalone build complete.
`ifndef LINE_ADDR_BITS
`define LINE_ADDR_BITS 16
`endif
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 6
`endif

package llc_arb_pkg;

  localparam int LLC_ADDR_W = `LINE_ADDR_BITS;
  localparam int LLC_SET_W  = `LLC_SET_BITS;
  localparam int LLC_TAG_W  = LLC_ADDR_W - LLC_SET_W;
  // Wide enough for all five LLC input classes (rst/rsp/req/dma/resume).
  localparam int LLC_SRC_W  = 3;

  // One arbitration decision as seen by the lookup stage.
  typedef struct packed {
    logic [LLC_SRC_W-1:0] src;
    logic [LLC_SET_W-1:0] set;
    logic [LLC_TAG_W-1:0] tag;
  } arb_entry_t;

  // Set is the low part of the line address, tag the remainder.
  function automatic arb_entry_t split_line_addr(input logic [LLC_SRC_W-1:0]  src,
                                                 input logic [LLC_ADDR_W-1:0] addr);
    arb_entry_t e;
    e.src = src;
    e.set = addr[LLC_SET_W-1:0];
    e.tag = addr[LLC_ADDR_W-1:LLC_SET_W];
    return e;
  endfunction

endpackage

// File: rtl/llc_arb_fifo.sv
// Circular decision FIFO between the arbiter and the LLC lookup stage.
// Head entry reads as all-zero while the FIFO is empty.
module llc_arb_fifo
  import llc_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  arb_entry_t                   din,
  output arb_entry_t                   dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  arb_entry_t       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Storage, pointers and occupancy; reset discards every queued entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == CNT_W'(0));
  assign dout  = empty ? '0 : mem_r[rd_ptr_r];

endmodule

// File: rtl/llc_input_arbiter.sv
// LLC input arbiter: fixed-priority source select (index 0 highest) under
// per-source block masks, decision FIFO, idle flag and stalled-line match.
// Optional starvation aging is enabled by defining LLC_ARB_AGING_EN.
`ifndef LINE_ADDR_BITS
`define LINE_ADDR_BITS 16
`endif
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 6
`endif

module llc_input_arbiter
  import llc_arb_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DEPTH     = 2,
  parameter int ADDR_W    = `LINE_ADDR_BITS,
  parameter int SET_W     = `LLC_SET_BITS,
  parameter int MATCH_SRC = 1,
  parameter int AGE_MAX   = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_SRC-1:0]                           src_valid,
  input  logic [NUM_SRC-1:0]                           src_block,
  input  logic [NUM_SRC*ADDR_W-1:0]                    src_addr,
  output logic [NUM_SRC-1:0]                           src_grant,
  input  logic                                         hold,
  output logic                                         dec_valid,
  input  logic                                         dec_ready,
  output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] dec_src,
  output logic [SET_W-1:0]                             dec_set,
  output logic [ADDR_W-SET_W-1:0]                      dec_tag,
  output logic                                         fifo_full,
  output logic [$clog2(DEPTH+1)-1:0]                   fifo_count,
  output logic                                         idle,
  input  logic                                         stall_valid,
  input  logic [SET_W-1:0]                             stall_set,
  input  logic [ADDR_W-SET_W-1:0]                      stall_tag,
  output logic                                         match_hit
);

  localparam int SRC_IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int TAG_W     = ADDR_W - SET_W;

  logic [NUM_SRC-1:0]   eligible_s;
  logic                 any_elig_s;
  logic                 fixed_hit_s;
  logic [SRC_IDX_W-1:0] fixed_idx_s;
  logic [SRC_IDX_W-1:0] winner_idx_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 empty_s;
  logic [ADDR_W-1:0]    winner_addr_s;
  arb_entry_t           push_entry_s;
  arb_entry_t           head_s;
  logic                 idle_r;

  assign eligible_s = src_valid & ~src_block;
  assign any_elig_s = |eligible_s;

  // Lowest eligible index wins under fixed priority.
  always_comb begin
    fixed_hit_s = 1'b0;
    fixed_idx_s = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible_s[i]) begin
        fixed_hit_s = 1'b1;
        fixed_idx_s = SRC_IDX_W'(i);
      end else begin
        fixed_hit_s = fixed_hit_s;
      end
    end
  end

`ifdef LLC_ARB_AGING_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  logic [AGE_W-1:0]     age_r [NUM_SRC];
  logic                 aged_hit_s;
  logic [SRC_IDX_W-1:0] aged_idx_s;

  // Lowest eligible source that has reached the starvation threshold.
  always_comb begin
    aged_hit_s = 1'b0;
    aged_idx_s = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible_s[i] && (age_r[i] == AGE_W'(AGE_MAX))) begin
        aged_hit_s = 1'b1;
        aged_idx_s = SRC_IDX_W'(i);
      end else begin
        aged_hit_s = aged_hit_s;
      end
    end
  end

  assign winner_idx_s = aged_hit_s ? aged_idx_s : fixed_idx_s;

  // Age bookkeeping only moves on a grant, so it freezes under hold or full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        age_r[i] <= '0;
      end
    end else if (push_s) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (winner_idx_s == SRC_IDX_W'(i)) begin
          age_r[i] <= '0;
        end else if (eligible_s[i] && (age_r[i] != AGE_W'(AGE_MAX))) begin
          age_r[i] <= age_r[i] + AGE_W'(1);
        end else begin
          age_r[i] <= age_r[i];
        end
      end
    end
  end
`else
  assign winner_idx_s = fixed_idx_s;
`endif

  // No decision while frozen, full, or in the reset cycle itself.
  assign push_s = ~rst & fixed_hit_s & ~hold & ~fifo_full;
  assign pop_s  = dec_valid & dec_ready;

  assign winner_addr_s = src_addr[int'(winner_idx_s) * ADDR_W +: ADDR_W];
  assign push_entry_s  = split_line_addr(LLC_SRC_W'(winner_idx_s), LLC_ADDR_W'(winner_addr_s));

  // One-hot consume pulse to the winning source in the push cycle.
  always_comb begin
    src_grant = '0;
    if (push_s) begin
      src_grant[winner_idx_s] = 1'b1;
    end else begin
      src_grant = '0;
    end
  end

  llc_arb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .dout  (head_s),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (empty_s)
  );

  assign dec_valid = ~empty_s;
  assign dec_src   = SRC_IDX_W'(head_s.src);
  assign dec_set   = SET_W'(head_s.set);
  assign dec_tag   = TAG_W'(head_s.tag);

  // Stalled line drains: only a popped decision from the match source counts.
  assign match_hit = pop_s & stall_valid
                   & (head_s.src == LLC_SRC_W'(MATCH_SRC))
                   & (head_s.set == LLC_SET_W'(stall_set))
                   & (head_s.tag == LLC_TAG_W'(stall_tag));

  // Idle means nothing queued and nobody asking, as of the previous cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_r <= 1'b0;
    end else begin
      idle_r <= (fifo_count == '0) & ~any_elig_s;
    end
  end

  assign idle = idle_r;

endmodule

// File: tb/tb_llc_input_arbiter.sv
// Self-checking bench for llc_input_arbiter: grant table, directed corner
// sequences and a randomized phase against a queue-based reference model.
module tb_llc_input_arbiter;
  import llc_arb_pkg::*;

  localparam int NUM_SRC   = 4;
  localparam int DEPTH     = 2;
  localparam int ADDR_W    = LLC_ADDR_W;
  localparam int SET_W     = LLC_SET_W;
  localparam int TAG_W     = ADDR_W - SET_W;
  localparam int MATCH_SRC = 1;
  localparam int AGE_MAX   = 3;

  logic                      clk;
  logic                      rst;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_block;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC-1:0]        src_grant;
  logic                      hold;
  logic                      dec_valid;
  logic                      dec_ready;
  logic [1:0]                dec_src;
  logic [SET_W-1:0]          dec_set;
  logic [TAG_W-1:0]          dec_tag;
  logic                      fifo_full;
  logic [1:0]                fifo_count;
  logic                      idle;
  logic                      stall_valid;
  logic [SET_W-1:0]          stall_set;
  logic [TAG_W-1:0]          stall_tag;
  logic                      match_hit;

  llc_input_arbiter #(
    .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SET_W(SET_W),
    .MATCH_SRC(MATCH_SRC), .AGE_MAX(AGE_MAX)
  ) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_block(src_block),
    .src_addr(src_addr), .src_grant(src_grant), .hold(hold),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_src(dec_src),
    .dec_set(dec_set), .dec_tag(dec_tag), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .idle(idle), .stall_valid(stall_valid),
    .stall_set(stall_set), .stall_tag(stall_tag), .match_hit(match_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  typedef struct { int src; logic [ADDR_W-1:0] addr; } mentry_t;
  mentry_t q[$];
  bit      idle_m;
  int      age_m [NUM_SRC];

  // Values sampled by the last step, for directed checks
  logic [NUM_SRC-1:0] last_grant;
  logic               last_idle;
  logic               last_match;
  logic [1:0]         last_dec_src;
  logic [SET_W-1:0]   last_dec_set;
  logic [TAG_W-1:0]   last_dec_tag;

  typedef struct { logic [3:0] valid; logic [3:0] block; logic hold; logic [3:0] grant; } vec_t;
  vec_t vecs [8];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int model_winner();
    int w = -1;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (src_valid[i] && !src_block[i]) w = i;
`ifdef LLC_ARB_AGING_EN
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (src_valid[i] && !src_block[i] && age_m[i] >= AGE_MAX) w = i;
`endif
    return w;
  endfunction

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
    src_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic model_clear();
    q.delete();
    idle_m = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) age_m[i] = 0;
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic step();
    int w, hs, hset, htag;
    bit push, pop, mexp;
    logic [3:0] gexp;
    w    = model_winner();
    push = (w >= 0) && !hold && (q.size() < DEPTH);
    gexp = push ? 4'(1 << w) : 4'd0;
    pop  = (q.size() > 0) && dec_ready;
    hs = 0; hset = 0; htag = 0;
    if (q.size() > 0) begin
      hs   = q[0].src;
      hset = int'(q[0].addr) % (1 << SET_W);
      htag = int'(q[0].addr) / (1 << SET_W);
    end
    mexp = pop && stall_valid && (hs == MATCH_SRC) && (hset == int'(stall_set)) && (htag == int'(stall_tag));
    #5;
    check("src_grant",  32'(src_grant),  32'(gexp));
    check("dec_valid",  32'(dec_valid),  32'(q.size() > 0));
    check("dec_src",    32'(dec_src),    32'(hs));
    check("dec_set",    32'(dec_set),    32'(hset));
    check("dec_tag",    32'(dec_tag),    32'(htag));
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("fifo_full",  32'(fifo_full),  32'(q.size() == DEPTH));
    check("idle",       32'(idle),       32'(idle_m));
    check("match_hit",  32'(match_hit),  32'(mexp));
    last_grant = src_grant; last_idle = idle; last_match = match_hit;
    last_dec_src = dec_src; last_dec_set = dec_set; last_dec_tag = dec_tag;
    @(posedge clk);
`ifdef LLC_ARB_AGING_EN
    if (push)
      for (int i = 0; i < NUM_SRC; i++) begin
        if (i == w) age_m[i] = 0;
        else if (src_valid[i] && !src_block[i] && age_m[i] < AGE_MAX) age_m[i]++;
      end
`endif
    idle_m = (q.size() == 0) && ((src_valid & ~src_block) == 4'd0);
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{w, src_addr[w*ADDR_W +: ADDR_W]});
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_valid = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int ngr;
    vecs[0] = '{4'b1110, 4'b0010, 1'b0, 4'b0100};
    vecs[1] = '{4'b0001, 4'b0000, 1'b0, 4'b0001};
    vecs[2] = '{4'b1111, 4'b0000, 1'b1, 4'b0000};
    vecs[3] = '{4'b1111, 4'b1111, 1'b0, 4'b0000};
    vecs[4] = '{4'b1000, 4'b0000, 1'b0, 4'b1000};
    vecs[5] = '{4'b1010, 4'b1000, 1'b0, 4'b0010};
    vecs[6] = '{4'b0000, 4'b0000, 1'b0, 4'b0000};
    vecs[7] = '{4'b1100, 4'b0100, 1'b0, 4'b1000};

    rst = 1'b1; src_valid = 4'd0; src_block = 4'd0; src_addr = '0; hold = 1'b0;
    dec_ready = 1'b0; stall_valid = 1'b0; stall_set = '0; stall_tag = '0;
    model_clear();
    // Reset state
    #3;
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_idle", 32'(idle), 32'd0);
    check("rst_grant", 32'(src_grant), 32'd0);
    check("rst_match", 32'(match_hit), 32'd0);
    check("rst_dec_tag", 32'(dec_tag), 32'd0);
    do_reset();

    // Grant table (consumer always ready, so the FIFO never fills)
    for (int i = 0; i < NUM_SRC; i++) set_addr(i, ADDR_W'(16'h1232 + 16'(i)));
    dec_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      src_valid = vecs[k].valid; src_block = vecs[k].block; hold = vecs[k].hold;
      step();
      check("vec_grant", 32'(last_grant), 32'(vecs[k].grant));
      if (k == 1) begin
        check("prio_dec_src", 32'(last_dec_src), 32'd2);
        check("prio_dec_set", 32'(last_dec_set), 32'h34);
        check("prio_dec_tag", 32'(last_dec_tag), 32'h48);
      end
    end
    hold = 1'b0; src_block = 4'd0;

    // Full FIFO backpressure
    do_reset();
    dec_ready = 1'b0; src_valid = 4'b0001;
    ngr = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (last_grant != 4'd0) ngr++;
    end
    check("full_grants", 32'(ngr), 32'd2);
    check("full_flag", 32'(fifo_full), 32'd1);
    dec_ready = 1'b1;
    step();
    check("full_pop_nogrant", 32'(last_grant), 32'd0);
    check("full_count_after", 32'(fifo_count), 32'd1);
    dec_ready = 1'b0;
    step();
    check("full_grant_resume", 32'(last_grant), 32'b0001);

    // Reset with two entries queued
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    rst = 1'b1;
    #1;
    check("midrst_dec_valid", 32'(dec_valid), 32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_idle", 32'(idle), 32'd0);
    check("midrst_grant", 32'(src_grant), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_grant2", 32'(src_grant), 32'd0);
    rst = 1'b0;
    model_clear();
    step();
    check("post_rst_grant", 32'(last_grant), 32'b0001);
    src_valid = 4'd0; dec_ready = 1'b1;
    repeat (3) step();

    // Stalled-line match
    stall_valid = 1'b1; stall_set = SET_W'(5); stall_tag = TAG_W'(3);
    set_addr(1, ADDR_W'((3 << SET_W) | 5));
    set_addr(0, ADDR_W'((3 << SET_W) | 5));
    src_valid = 4'b0010; step();
    src_valid = 4'b0000; dec_ready = 1'b0; step();
    check("match_no_pop", 32'(last_match), 32'd0);
    dec_ready = 1'b1; step();
    check("match_src1", 32'(last_match), 32'd1);
    src_valid = 4'b0001; step();
    src_valid = 4'b0000; step();
    check("match_src0", 32'(last_match), 32'd0);
    stall_valid = 1'b0;

    // Idle flag
    do_reset();
    step(); step();
    check("idle_set", 32'(last_idle), 32'd1);
    src_valid = 4'b0100; step();
    src_valid = 4'b0000; step();
    check("idle_clear", 32'(last_idle), 32'd0);

`ifdef LLC_ARB_AGING_EN
    begin
      int exp_seq [8] = '{0, 0, 0, 3, 0, 0, 0, 3};
      do_reset();
      dec_ready = 1'b1; src_valid = 4'b1001;
      for (int k = 0; k < 8; k++) begin
        step();
        check("aging_grant", 32'(last_grant), 32'(1 << exp_seq[k]));
      end
    end
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      src_valid   = 4'($urandom);
      src_block   = 4'($urandom) & 4'($urandom);
      hold        = ($urandom % 8) == 0;
      dec_ready   = ($urandom % 4) != 0;
      stall_valid = 1'($urandom);
      stall_set   = SET_W'($urandom % 4);
      stall_tag   = TAG_W'($urandom % 4);
      for (int i = 0; i < NUM_SRC; i++)
        set_addr(i, ADDR_W'((($urandom % 4) << SET_W) | ($urandom % 4)));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
